// File: rtl/mem2_load_merge_pkg.sv
// Shared definitions for the MEM2 load-merge stage.
// Access size encodings, merge FSM states and default datapath width.
package mem2_load_merge_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_HI = 1'b1
    } merge_state_e;

endpackage

// File: rtl/mem2_load_merge_extract.sv
// Load data aligner: shifts a two-word byte window by the access offset
// and sign- or zero-extends the selected byte/half/word/double.
module load_extract
    import mem2_load_merge_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] lo_word,
    input  logic [XLEN-1:0] hi_word,
    input  logic [OFFW-1:0] off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] win;
    logic [63:0]       sh;
    logic [1:0]        sz;

    assign win = {hi_word, lo_word};
    assign sh  = 64'(win >> {off, 3'b000});
    // A doubleword on a 32-bit datapath degrades to a word.
    assign sz  = (XLEN == 32 && size == SZ_D) ? 2'(SZ_W) : size;

    // Pick the field and extend it to XLEN.
    always_comb begin
        result = '0;
        unique case (sz)
            2'd0: begin
                if (is_unsigned) result = XLEN'(sh[7:0]);
                else             result = XLEN'($signed(sh[7:0]));
            end
            2'd1: begin
                if (is_unsigned) result = XLEN'(sh[15:0]);
                else             result = XLEN'($signed(sh[15:0]));
            end
            2'd2: begin
                if (is_unsigned) result = XLEN'(sh[31:0]);
                else             result = XLEN'($signed(sh[31:0]));
            end
            default: result = XLEN'(sh);
        endcase
    end

endmodule

// File: rtl/mem2_load_merge.sv
// MEM2 stage: registers the MEM1 payload, aligns load data and merges
// misaligned loads that arrive as two consecutive beats.
module mem2_load_merge
    import mem2_load_merge_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall_self,
    input  logic            stall_next,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_rdata,
    input  logic            in_is_load,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [OFFW-1:0] in_off,
    input  logic            in_split,
    input  logic            in_beat,
    input  logic            in_rf_we,
    input  logic [4:0]      in_rf_waddr,
    input  logic [XLEN-1:0] in_ex_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    output logic            out_rf_we,
    output logic [4:0]      out_rf_waddr,
    output logic [XLEN-1:0] out_rf_wdata,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            fwd_we,
    output logic [4:0]      fwd_waddr,
    output logic [XLEN-1:0] fwd_wdata,
    output logic            stall_req,
    output logic            split_err
);

    logic            r_valid;
    logic [XLEN-1:0] r_rdata;
    logic            r_is_load;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [OFFW-1:0] r_off;
    logic            r_split;
    logic            r_beat;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_ex;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;

    logic [XLEN-1:0] b_lo;
    logic [OFFW-1:0] b_off;
    logic [1:0]      b_size;
    logic            b_uns;

    merge_state_e    st;
    merge_state_e    st_n;

    logic            beat0;
    logic            beat1;
    logic            advance;
    logic            ld_buf;
    logic            merge_sel;
    logic            valid_c;
    logic            stall_c;
    logic            err_c;

    logic [XLEN-1:0] x_lo;
    logic [XLEN-1:0] x_hi;
    logic [OFFW-1:0] x_off;
    logic [1:0]      x_size;
    logic            x_uns;
    logic [XLEN-1:0] x_res;
    logic [XLEN-1:0] wdata;

    assign beat0   = r_valid & r_split & ~r_beat;
    assign beat1   = r_valid & r_beat;
    assign advance = ~(stall_self & stall_next);

    // Stage register: clear, bubble, load or hold.
    always_ff @(posedge clk) begin
        if (rst || flush || (stall_self && !stall_next)) begin
            r_valid    <= 1'b0;
            r_rdata    <= '0;
            r_is_load  <= 1'b0;
            r_size     <= '0;
            r_uns      <= 1'b0;
            r_off      <= '0;
            r_split    <= 1'b0;
            r_beat     <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_ex       <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
        end else if (!stall_self) begin
            r_valid    <= in_valid;
            r_rdata    <= in_rdata;
            r_is_load  <= in_is_load;
            r_size     <= in_size;
            r_uns      <= in_unsigned;
            r_off      <= in_off;
            r_split    <= in_split;
            r_beat     <= in_beat;
            r_rf_we    <= in_rf_we;
            r_rf_waddr <= in_rf_waddr;
            r_ex       <= in_ex_result;
            r_pc       <= in_pc;
            r_inst     <= in_inst;
        end
    end

    // Merge FSM state and low-beat buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            st     <= ST_IDLE;
            b_lo   <= '0;
            b_off  <= '0;
            b_size <= '0;
            b_uns  <= 1'b0;
        end else if (advance) begin
            st <= st_n;
            if (ld_buf) begin
                b_lo   <= r_rdata;
                b_off  <= r_off;
                b_size <= r_size;
                b_uns  <= r_uns;
            end
        end
    end

    // Next state and per-entry outcome of the registered payload.
    always_comb begin
        st_n      = st;
        ld_buf    = 1'b0;
        merge_sel = 1'b0;
        valid_c   = 1'b0;
        stall_c   = 1'b0;
        err_c     = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (beat1) begin
                    err_c = 1'b1;
                end else if (beat0) begin
                    ld_buf = 1'b1;
                    st_n   = ST_WAIT_HI;
                end else if (r_valid) begin
                    valid_c = 1'b1;
                end
            end
            default: begin
                stall_c = 1'b1;
                if (beat1) begin
                    valid_c   = 1'b1;
                    merge_sel = 1'b1;
                    stall_c   = 1'b0;
                    st_n      = ST_IDLE;
                end else if (r_valid) begin
                    err_c   = 1'b1;
                    stall_c = 1'b0;
                    st_n    = ST_IDLE;
                end
            end
        endcase
    end

    assign x_lo   = merge_sel ? b_lo : r_rdata;
    assign x_hi   = merge_sel ? r_rdata : '0;
    assign x_off  = merge_sel ? b_off : r_off;
    assign x_size = merge_sel ? b_size : r_size;
    assign x_uns  = merge_sel ? b_uns : r_uns;

    load_extract #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_extract (
        .lo_word     (x_lo),
        .hi_word     (x_hi),
        .off         (x_off),
        .size        (x_size),
        .is_unsigned (x_uns),
        .result      (x_res)
    );

    assign wdata = r_is_load ? x_res : r_ex;

    assign out_valid    = valid_c;
    assign out_rf_we    = r_rf_we & valid_c;
    assign out_rf_waddr = r_rf_waddr;
    assign out_rf_wdata = wdata;
    assign out_pc       = r_pc;
    assign out_inst     = r_inst;
    assign fwd_we       = r_rf_we & valid_c;
    assign fwd_waddr    = r_rf_waddr;
    assign fwd_wdata    = wdata;
    assign stall_req    = stall_c;
    assign split_err    = err_c;

endmodule

// File: tb/tb_mem2_load_merge.sv
// Directed bench for mem2_load_merge (XLEN=64 and XLEN=32 instances).
// Each scenario task drives vectors and checks hand-computed results.
module tb_mem2_load_merge;

    logic        clk = 1'b0;
    logic        rst, flush, stall_self, stall_next;
    logic        in_valid, in_is_load, in_unsigned, in_split, in_beat;
    logic        in_rf_we;
    logic [1:0]  in_size;
    logic [2:0]  in_off;
    logic [4:0]  in_rf_waddr;
    logic [31:0] in_inst;
    logic [63:0] rdata64, ex64, pc64;
    logic [31:0] rdata32, ex32, pc32;

    logic        o_valid, o_we, o_fwe, o_stall, o_err;
    logic [4:0]  o_waddr, o_fwaddr;
    logic [63:0] o_wdata, o_pc, o_fwdata;
    logic [31:0] o_inst;

    logic        p_valid, p_we, p_fwe, p_stall, p_err;
    logic [4:0]  p_waddr, p_fwaddr;
    logic [31:0] p_wdata, p_pc, p_fwdata, p_inst;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem2_load_merge #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .flush(flush),
        .stall_self(stall_self), .stall_next(stall_next),
        .in_valid(in_valid), .in_rdata(rdata64),
        .in_is_load(in_is_load), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_off(in_off),
        .in_split(in_split), .in_beat(in_beat),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_ex_result(ex64), .in_pc(pc64), .in_inst(in_inst),
        .out_valid(o_valid), .out_rf_we(o_we),
        .out_rf_waddr(o_waddr), .out_rf_wdata(o_wdata),
        .out_pc(o_pc), .out_inst(o_inst),
        .fwd_we(o_fwe), .fwd_waddr(o_fwaddr), .fwd_wdata(o_fwdata),
        .stall_req(o_stall), .split_err(o_err)
    );

    mem2_load_merge #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .flush(flush),
        .stall_self(stall_self), .stall_next(stall_next),
        .in_valid(in_valid), .in_rdata(rdata32),
        .in_is_load(in_is_load), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_off(in_off[1:0]),
        .in_split(in_split), .in_beat(in_beat),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_ex_result(ex32), .in_pc(pc32), .in_inst(in_inst),
        .out_valid(p_valid), .out_rf_we(p_we),
        .out_rf_waddr(p_waddr), .out_rf_wdata(p_wdata),
        .out_pc(p_pc), .out_inst(p_inst),
        .fwd_we(p_fwe), .fwd_waddr(p_fwaddr), .fwd_wdata(p_fwdata),
        .stall_req(p_stall), .split_err(p_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] rd,
                         input logic ld, input logic [1:0] sz,
                         input logic un, input logic [2:0] of,
                         input logic sp, input logic bt,
                         input logic we, input logic [4:0] wa,
                         input logic [63:0] ex, input logic [63:0] pc);
        in_valid    = v;
        rdata64     = rd;
        in_is_load  = ld;
        in_size     = sz;
        in_unsigned = un;
        in_off      = of;
        in_split    = sp;
        in_beat     = bt;
        in_rf_we    = we;
        in_rf_waddr = wa;
        ex64        = ex;
        pc64        = pc;
        in_inst     = pc[31:0] | 32'h3;
        rdata32     = rd[31:0];
        ex32        = ex[31:0];
        pc32        = pc[31:0];
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; stall_self = 0; stall_next = 0;
        drive(1, 64'h1234, 1, 2'd2, 0, 0, 0, 0, 1, 5'd3, 64'h55, 64'h40);
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_we !== 1'b0 || o_fwe !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b%b%b exp=000", o_valid, o_we, o_fwe);
        end
        checks++;
        if (o_wdata !== 64'h0 || o_pc !== 64'h0 || o_inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", o_wdata, o_pc, o_inst);
        end
        checks++;
        if (o_stall !== 1'b0 || o_err !== 1'b0 || o_waddr !== 5'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b%b/%0d exp=00/0", o_stall, o_err, o_waddr);
        end
        rst = 0;
    endtask

    task automatic test_lb();
        drive(1, 64'h8000, 1, 2'd0, 0, 3'd1, 0, 0, 1, 5'd5, 64'h0, 64'h100);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            failures++;
            $display("FAIL lb got=%b/%h exp=1/ffffffffffffff80", o_valid, o_wdata);
        end
        checks++;
        if (o_we !== 1'b1 || o_fwe !== 1'b1 || o_fwaddr !== 5'd5
            || o_fwdata !== 64'hFFFF_FFFF_FFFF_FF80 || o_pc !== 64'h100) begin
            failures++;
            $display("FAIL lb_fwd got=%b%b/%0d/%h/%h", o_we, o_fwe, o_fwaddr, o_fwdata, o_pc);
        end
    endtask

    task automatic test_lwu();
        drive(1, 64'hDEAD_BEEF_1234_5678, 1, 2'd2, 1, 3'd4, 0, 0, 1, 5'd6, 0, 64'h104);
        tick();
        checks++;
        if (o_wdata !== 64'h0000_0000_DEAD_BEEF) begin
            failures++;
            $display("FAIL lwu got=%h exp=00000000deadbeef", o_wdata);
        end
        drive(1, 64'hDEAD_BEEF_1234_5678, 1, 2'd1, 0, 3'd2, 0, 0, 1, 5'd6, 0, 64'h108);
        tick();
        checks++;
        if (o_wdata !== 64'h0000_0000_0000_1234) begin
            failures++;
            $display("FAIL lh got=%h exp=0000000000001234", o_wdata);
        end
    endtask

    task automatic test_alu();
        drive(1, 64'hFFFF, 0, 2'd3, 0, 3'd0, 0, 0, 0, 5'd9, 64'hABCD_0000_1234, 64'h10C);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_wdata !== 64'hABCD_0000_1234 || o_we !== 1'b0) begin
            failures++;
            $display("FAIL alu got=%b/%h/%b exp=1/abcd00001234/0", o_valid, o_wdata, o_we);
        end
    endtask

    task automatic test_split();
        drive(1, 64'hAABB_0000_0000_0000, 1, 2'd2, 0, 3'd6, 1, 0, 1, 5'd7, 0, 64'h200);
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_we !== 1'b0) begin
            failures++;
            $display("FAIL split_b0 got=%b%b%b exp=000", o_valid, o_stall, o_we);
        end
        bubble();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_stall !== 1'b1) begin
            failures++;
            $display("FAIL split_wait got=%b%b exp=01", o_valid, o_stall);
        end
        drive(1, 64'hCCDD, 1, 2'd2, 0, 3'd0, 1, 1, 1, 5'd7, 0, 64'h204);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_wdata !== 64'hFFFF_FFFF_CCDD_AABB
            || o_stall !== 1'b0 || o_pc !== 64'h204) begin
            failures++;
            $display("FAIL split_merge got=%b/%h/%b/%h exp=1/ffffffffccddaabb/0/204",
                     o_valid, o_wdata, o_stall, o_pc);
        end
        bubble();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL split_idle got=%b%b%b exp=000", o_valid, o_stall, o_err);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 64'h3400_0000_0000_0000, 1, 2'd1, 1, 3'd7, 1, 0, 1, 5'd8, 0, 64'h300);
        tick();
        drive(1, 64'hFFFF_FFFF_FFFF_FF12, 1, 2'd1, 1, 3'd0, 1, 1, 1, 5'd8, 0, 64'h304);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_wdata !== 64'h1234 || o_we !== 1'b1) begin
            failures++;
            $display("FAIL b2b_lhu got=%b/%h/%b exp=1/1234/1", o_valid, o_wdata, o_we);
        end
        bubble();
        tick();
    endtask

    task automatic test_flush();
        drive(1, 64'h1100_0000_0000_0000, 1, 2'd2, 0, 3'd6, 1, 0, 1, 5'd10, 0, 64'h400);
        tick();
        bubble();
        tick();
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre got=%b exp=1", o_stall);
        end
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got=%b%b exp=00", o_stall, o_valid);
        end
        drive(1, 64'h2222, 1, 2'd2, 0, 3'd0, 1, 1, 1, 5'd10, 0, 64'h404);
        tick();
        checks++;
        if (o_err !== 1'b1 || o_valid !== 1'b0 || o_we !== 1'b0 || o_fwe !== 1'b0) begin
            failures++;
            $display("FAIL flush_err got=%b%b%b%b exp=1000", o_err, o_valid, o_we, o_fwe);
        end
        bubble();
        tick();
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse got=%b exp=0", o_err);
        end
    endtask

    task automatic test_stall();
        drive(1, 64'h7F, 1, 2'd0, 0, 3'd0, 0, 0, 1, 5'd11, 0, 64'h500);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_wdata !== 64'h7F) begin
            failures++;
            $display("FAIL stall_pre got=%b/%h exp=1/7f", o_valid, o_wdata);
        end
        stall_self = 1; stall_next = 0;
        drive(1, 64'h99, 0, 2'd0, 0, 3'd0, 0, 0, 1, 5'd12, 64'h99, 64'h504);
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_we !== 1'b0 || o_wdata !== 64'h0) begin
            failures++;
            $display("FAIL bubble got=%b%b/%h exp=00/0", o_valid, o_we, o_wdata);
        end
        stall_self = 0;
        drive(1, 0, 0, 2'd0, 0, 3'd0, 0, 0, 1, 5'd13, 64'hABC, 64'h508);
        tick();
        stall_self = 1; stall_next = 1;
        drive(1, 0, 0, 2'd0, 0, 3'd0, 0, 0, 1, 5'd14, 64'h555, 64'h50C);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_wdata !== 64'hABC
                || o_pc !== 64'h508 || o_waddr !== 5'd13) begin
                failures++;
                $display("FAIL hold%0d got=%b/%h/%h/%0d exp=1/abc/508/13",
                         i, o_valid, o_wdata, o_pc, o_waddr);
            end
        end
        stall_self = 0; stall_next = 0;
        bubble();
        tick();
    endtask

    task automatic test_xlen32();
        drive(1, 64'h8000_0000, 1, 2'd3, 0, 3'd0, 0, 0, 1, 5'd15, 0, 64'h600);
        tick();
        checks++;
        if (p_valid !== 1'b1 || p_wdata !== 32'h8000_0000) begin
            failures++;
            $display("FAIL x32_ld got=%b/%h exp=1/80000000", p_valid, p_wdata);
        end
        drive(1, 64'hAB00_0000, 1, 2'd2, 0, 3'd3, 1, 0, 1, 5'd16, 0, 64'h604);
        tick();
        bubble();
        tick();
        checks++;
        if (p_stall !== 1'b1) begin
            failures++;
            $display("FAIL x32_wait got=%b exp=1", p_stall);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (p_valid !== 1'b0 || p_stall !== 1'b0 || p_err !== 1'b0
            || p_we !== 1'b0 || p_fwe !== 1'b0) begin
            failures++;
            $display("FAIL x32_rst_ctrl got=%b%b%b%b%b exp=00000",
                     p_valid, p_stall, p_err, p_we, p_fwe);
        end
        checks++;
        if (p_wdata !== 32'h0 || p_pc !== 32'h0 || p_inst !== 32'h0
            || p_waddr !== 5'd0 || p_fwdata !== 32'h0 || p_fwaddr !== 5'd0) begin
            failures++;
            $display("FAIL x32_rst_data got=%h/%h/%h/%0d exp=0",
                     p_wdata, p_pc, p_inst, p_waddr);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lwu();
        test_alu();
        test_split();
        test_back_to_back();
        test_flush();
        test_stall();
        test_xlen32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
